// File: rtl/gray_seq_monitor.sv
// Gray-code stream monitor: converts 3-bit gray samples to binary, checks for legal
// single-step increments, counts errors/wraps and latches a sticky fault on error bursts.
module gray_seq_monitor #(
   parameter int unsigned W          = 3,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned MAX_CONSEC = 3,
   parameter int unsigned ALLOW_HOLD = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     gray_in,
   input  logic             valid_in,
   input  logic             clear_i,
   output logic [W-1:0]     bin_out,
   output logic             bin_valid,
   output logic             err_pulse,
   output logic             wrap_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] wrap_count,
   output logic [1:0]       state_o
);

   localparam int unsigned CW = $clog2(MAX_CONSEC + 1);

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      TRACK   = 2'd1,
      FAULT   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     bin_c, prev, prev_nxt;
   logic [CW-1:0]    consec, consec_nxt, consec_inc;
   logic [CNT_W-1:0] err_cnt_nxt, wrap_cnt_nxt;
   logic             check_c, step_c, hold_c, bad_c, err_c, wrap_c, fault_c;

   // Gray to binary: each binary bit is the XOR of all gray bits at or above it
   always_comb begin
      bin_c = '0;
      for (int i = 0; i < W; i++) begin
         bin_c = bin_c ^ (gray_in >> i);
      end
   end

   assign check_c    = valid_in && !clear_i && (state == TRACK);
   assign step_c     = (bin_c == prev + W'(1));
   assign hold_c     = (bin_c == prev);
   assign bad_c      = !(step_c || (hold_c && (ALLOW_HOLD != 0)));
   assign err_c      = check_c && bad_c;
   assign wrap_c     = check_c && step_c && (prev == '1);
   assign consec_inc = consec + CW'(1);
   assign fault_c    = err_c && (consec_inc >= CW'(MAX_CONSEC));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ACQUIRE;
      else      state <= state_nxt;
   end

   // Next-state logic; clear wins over any sample
   always_comb begin
      state_nxt = state;
      if (clear_i) begin
         state_nxt = ACQUIRE;
      end else if (valid_in) begin
         case (state)
            ACQUIRE: state_nxt = TRACK;
            TRACK:   state_nxt = fault_c ? FAULT : TRACK;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = ACQUIRE;
         endcase
      end
   end

   // Reference, consecutive-error and statistics updates
   always_comb begin
      prev_nxt     = prev;
      consec_nxt   = consec;
      err_cnt_nxt  = err_count;
      wrap_cnt_nxt = wrap_count;
      if (clear_i) begin
         consec_nxt   = '0;
         err_cnt_nxt  = '0;
         wrap_cnt_nxt = '0;
      end else if (valid_in) begin
         prev_nxt = bin_c;
         if (state == ACQUIRE) consec_nxt = '0;
         if (state == TRACK) begin
            consec_nxt = bad_c ? consec_inc : '0;
            if (err_c && (err_count != '1))   err_cnt_nxt  = err_count + CNT_W'(1);
            if (wrap_c && (wrap_count != '1)) wrap_cnt_nxt = wrap_count + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev       <= '0;
         consec     <= '0;
         err_count  <= '0;
         wrap_count <= '0;
         bin_out    <= '0;
         bin_valid  <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         prev       <= prev_nxt;
         consec     <= consec_nxt;
         err_count  <= err_cnt_nxt;
         wrap_count <= wrap_cnt_nxt;
         if (valid_in) bin_out <= bin_c;
         bin_valid  <= valid_in;
         err_pulse  <= err_c;
         wrap_pulse <= wrap_c;
      end
   end

   assign state_o = state;

endmodule
